// File: rtl/count4_sched.sv
// Round-robin scheduler sharing one loadable up/down counter between two requesters.
// Define COUNT4_SCHED_ABORT_EN to let an owner abort its job by dropping req.
module count4_sched #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [1:0]   dir,
    input  logic [W-1:0] load_val0,
    input  logic [W-1:0] load_val1,
    input  logic [W-1:0] count,
    output logic         set,
    output logic         dec,
    output logic [W-1:0] set_count,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
`ifdef COUNT4_SCHED_ABORT_EN
    output logic [1:0]   abort,
`endif
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]   state;
    logic         dir_q;
    logic         last;
    logic         win;
    logic         drop;
    logic [W-1:0] term;

    // last=1 means requester 1 won most recently, so requester 0 wins a tie
    always_comb begin
        win  = (req == 2'b10) | ((req == 2'b11) & ~last);
        term = dir_q ? '0 : '1;
`ifdef COUNT4_SCHED_ABORT_EN
        drop = |(gnt & ~req);
`else
        drop = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            set_count <= '0;
            dir_q     <= 1'b0;
            last      <= 1'b1;
            done      <= 2'b00;
`ifdef COUNT4_SCHED_ABORT_EN
            abort     <= 2'b00;
`endif
        end else begin
            done <= 2'b00;
`ifdef COUNT4_SCHED_ABORT_EN
            abort <= 2'b00;
`endif
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= win ? 2'b10 : 2'b01;
                        set_count <= win ? load_val1 : load_val0;
                        dir_q     <= dir[win];
                        last      <= win;
                        state     <= LOAD;
                    end
                end
                LOAD, RUN: begin
                    if (drop) begin
                        state <= IDLE;
                        gnt   <= 2'b00;
`ifdef COUNT4_SCHED_ABORT_EN
                        abort <= gnt;
`endif
                    end else if (state == LOAD) begin
                        state <= RUN;
                    end else if (count == term) begin
                        done  <= gnt;
                        gnt   <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign set  = (state == LOAD);
    assign dec  = (state == RUN) & dir_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_count4_sched.sv
// Scoreboarded bench for count4_sched driving a behavioural 4-bit up/down counter.
// Expected done pulses are queued at stimulus time and checked by a monitor.
module tb_count4_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] dir = 2'b00;
    logic [3:0] load_val0 = 4'h0;
    logic [3:0] load_val1 = 4'h0;
    logic [3:0] cnt = 4'h0;
    logic       set;
    logic       dec;
    logic [3:0] set_count;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
`ifdef COUNT4_SCHED_ABORT_EN
    logic [1:0] abort;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [1:0] val;
        int         at;
    } exp_t;
    exp_t q[$];

    count4_sched #(.W(4)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .dir(dir),
        .load_val0(load_val0),
        .load_val1(load_val1),
        .count(cnt),
        .set(set),
        .dec(dec),
        .set_count(set_count),
        .gnt(gnt),
        .done(done),
`ifdef COUNT4_SCHED_ABORT_EN
        .abort(abort),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // external counter that the scheduler steers
    always @(posedge clk) begin
        if (set)
            cnt <= set_count;
        else if (dec)
            cnt <= cnt - 4'd1;
        else
            cnt <= cnt + 4'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] val, input int at);
        exp_t e;
        e.val = val;
        e.at  = at;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (done != 2'b00) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got %b expected none (cycle %0d)",
                         done, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_val", int'(done), int'(e.val));
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    // single job; checks LOAD/RUN outputs cycle by cycle, releases req on done
    task automatic run_job(input int r, input logic d, input logic [3:0] lv);
        int t;
        int s;
        logic [3:0] ev;
        s = d ? int'(lv) : 15 - int'(lv);
        @(negedge clk);
        dir[r] = d;
        if (r == 0) load_val0 = lv;
        else        load_val1 = lv;
        req[r] = 1'b1;
        t = cyc;
        push_exp(2'b01 << r, t + s + 3);
        for (int k = 1; k <= s + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("load_set", int'(set), 1);
                chk("load_set_count", int'(set_count), int'(lv));
                chk("load_gnt", int'(gnt), 1 << r);
                chk("load_busy", int'(busy), 1);
            end else if (k <= s + 2) begin
                ev = d ? lv - 4'(k - 2) : lv + 4'(k - 2);
                chk("run_dec", int'(dec), int'(d));
                chk("run_set", int'(set), 0);
                chk("run_count", int'(cnt), int'(ev));
                chk("run_gnt", int'(gnt), 1 << r);
            end else begin
                chk("rel_gnt", int'(gnt), 0);
                chk("rel_busy", int'(busy), 0);
                req[r] = 1'b0;
            end
        end
    endtask

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_set", int'(set), 0);
        chk("rst_dec", int'(dec), 0);
        chk("rst_set_count", int'(set_count), 0);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_job(0, 1'b1, 4'd3);
        run_job(1, 1'b0, 4'hD);
        run_job(0, 1'b1, 4'd0);
        run_job(1, 1'b0, 4'hF);

        // contention with zero-step jobs: grants alternate every 3 cycles
        @(negedge clk);
        dir = 2'b01;
        load_val0 = 4'h0;
        load_val1 = 4'hF;
        req = 2'b11;
        t = cyc;
        push_exp(2'b01, t + 3);
        push_exp(2'b10, t + 6);
        push_exp(2'b01, t + 9);
        push_exp(2'b10, t + 12);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1 || k == 7) chk("alt_gnt0", int'(gnt), 1);
            if (k == 4 || k == 10) chk("alt_gnt1", int'(gnt), 2);
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("alt_idle", int'(busy), 0);

        // reset pulse in c3 of a 3-step down job
        @(negedge clk);
        dir[0] = 1'b1;
        load_val0 = 4'd3;
        req[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        req[0] = 1'b0;
        #1;
        chk("mid_rst_set", int'(set), 0);
        chk("mid_rst_dec", int'(dec), 0);
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_set_count", int'(set_count), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        run_job(0, 1'b1, 4'd2);

        // owner drops req in c3 of a 3-step down job
        @(negedge clk);
        dir[0] = 1'b1;
        load_val0 = 4'd3;
        req[0] = 1'b1;
        t = cyc;
`ifndef COUNT4_SCHED_ABORT_EN
        push_exp(2'b01, t + 6);
`endif
        repeat (3) @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
`ifdef COUNT4_SCHED_ABORT_EN
        chk("abort_pulse", int'(abort), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_gnt", int'(gnt), 0);
        @(negedge clk);
        chk("abort_clear", int'(abort), 0);
        @(negedge clk);
`else
        chk("noabort_busy", int'(busy), 1);
        chk("noabort_gnt", int'(gnt), 1);
        repeat (2) @(negedge clk);
`endif
        @(negedge clk);
        chk("final_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count4_sched.md
# count4_sched

Two-requester round-robin scheduler for the loadable up/down 4-bit counter. It grants the shared counter to one requester at a time, loads that requester's start value, and steers the counter up or down until it reaches the terminal value. It then pulses `done` to the owner and re-arbitrates. It sits directly in front of the counter: its `set`, `dec` and `set_count` outputs drive the counter, and its `count` input is the counter's output.

## Interface
- `W`, default 4: counter width; must match the counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-requester request.
- `dir`  in  2  per-requester direction; 1 = count down to 0, 0 = count up to 2^W-1.
- `load_val0`, `load_val1`  in  W  start values for requesters 0 and 1.
- `count`  in  W  current counter value.
- `set`  out  1  counter load strobe.
- `dec`  out  1  counter decrement select.
- `set_count`  out  W  value loaded into the counter.
- `gnt`  out  2  one-hot owner; 0 when idle.
- `done`  out  2  one-cycle completion pulse to the owner.
- `busy`  out  1  high in LOAD or RUN.

## Operation
- States:
  - IDLE: set=0, dec=0, gnt=0.
  - LOAD: set=1, dec=0.
  - RUN: set=0, dec=latched dir.
- IDLE, any `req` high at a clock edge:
  - Pick a winner; register `gnt`.
  - Latch the winner's `load_val` into `set_count` and its `dir`.
  - Go to LOAD.
- Arbitration:
  - Single request: that requester wins.
  - Both requesting: the requester that did not win last wins.
  - The last-winner pointer updates at grant. After reset the pointer marks requester 1 as last winner, so requester 0 has priority.
- LOAD: always lasts exactly one cycle, then RUN.
- RUN: terminal value is 0 if latched dir=1, else 2^W-1 (4'hF).
- RUN, `count` == terminal at an edge:
  - `done[owner]` goes high for the next cycle only.
  - `gnt` clears and state returns to IDLE.
- Overshoot: the counter steps once more on that same edge, wrapping to F (down) or 0 (up). The counter free-runs upward in IDLE. The scheduler ignores `count` outside RUN.
- Step count S = L when counting down, 2^W-1-L when counting up (L = start value).
- Start value equal to terminal: S = 0; terminal is detected in the first RUN cycle.
- `req` is sampled only in IDLE. Without the config feature, `req` changes during LOAD/RUN are ignored. `load_val` and `dir` are sampled only at the grant edge.
- IDLE cycle with `done` high also arbitrates; back-to-back grants are allowed.
- Reset, asserted at any time including mid-RUN:
  - State → IDLE, pointer → requester 1.
  - `set`, `dec`, `gnt`, `done`, `busy` = 0; `set_count` = 0; no `done` is issued.

## Timing
- c0 = IDLE cycle in which `req` is sampled high.
- c1: LOAD, with `gnt` and `busy` high.
- c2: first RUN cycle; `count` = L.
- c(S+2): RUN cycle in which terminal is seen.
- c(S+3): IDLE; `done` high, `gnt` and `busy` 0.
- Occupancy per job: S+2 cycles from grant to release. Minimum request-to-done latency is 3 cycles.
- All outputs are registered or decoded from registered state; no combinational path from `req` or `count` to any output.

## Configuration
- `COUNT4_SCHED_ABORT_EN` defined:
  - If the owner's `req` is low at an edge in LOAD or RUN, the job aborts.
  - State → IDLE, `gnt` clears, no `done`.
  - Adds output `abort` (2 bits), pulsed high for one cycle to the owner in the following cycle.
  - Requesters must hold `req` high until `done`.
- `COUNT4_SCHED_ABORT_EN` undefined:
  - No `abort` port.
  - Owner `req` is ignored after grant; a job always runs to `done`.

## Test plan
- Down job, single requester: req0=1, dir0=1, load_val0=3 at c0 → set=1 with set_count=3 in c1; dec=1 for c2–c5 with count 3,2,1,0; done=2'b01 in c6 only.
- Up job: req1=1, dir1=0, load_val1=4'hD → done[1] in cycle c5 (S=2); gnt=2'b10 from c1 to c4.
- Contention: both `req` held with 0-step jobs (start = terminal) → grants alternate 0,1,0,1; each done followed by the other requester's LOAD in the same IDLE cycle.
- Start equals terminal: dir0=1, load_val0=0 → done[0] in c3.
- Reset mid-RUN: reset pulse in c3 of a 3-step down job → all outputs 0 immediately, no done; next req0 is granted normally.
- Abort (macro on): drop req0 in c3 of a down job → state IDLE in c4, abort=2'b01 in c4, done never asserted; (macro off): same stimulus → done[0] at nominal cycle.
